// File: rtl/mem_access_unit.sv
// Initiator side of the data memory port: sequences single-word and burst
// loads/stores with a programmable per-word hold time and returns responses.
module mem_access_unit #(
    parameter int DEPTH       = 1024,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_len,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_last,
    output logic        mem_enable,
    output logic        rw_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // ACCESS | memory strobes driven, holding each word MEM_LATENCY cycles
    // RESP   | response presented, waiting for resp_ready
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [32:0] LAST_ADDR = 33'(DEPTH - 1);
    localparam logic [3:0]  LAST_WAIT = 4'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  word_q, word_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_last_q, resp_last_d;
    logic        mem_enable_q, mem_enable_d;
    logic        rw_enable_q, rw_enable_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;

    // 33-bit sum so an address near 2^32 cannot wrap into the legal range
    logic [32:0] end_addr;
    logic [3:0]  word_inc;
    logic [31:0] next_addr;

    assign end_addr  = {1'b0, req_addr} + {29'b0, req_len};
    assign word_inc  = word_q + 4'd1;
    assign next_addr = addr_q + {28'b0, word_inc};

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = write_q;
        len_d         = len_q;
        word_d        = word_q;
        wait_d        = wait_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        resp_last_d   = resp_last_q;
        mem_enable_d  = mem_enable_q;
        rw_enable_d   = rw_enable_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    write_d      = req_write;
                    len_d        = req_len;
                    word_d       = 4'd0;
                    wait_d       = 4'd0;
                    resp_rdata_d = 32'd0;
                    if (end_addr > LAST_ADDR) begin
                        resp_err_d  = 1'b1;
                        resp_last_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        resp_err_d    = 1'b0;
                        resp_last_d   = 1'b0;
                        mem_enable_d  = 1'b1;
                        rw_enable_d   = ~req_write;
                        mem_address_d = req_addr;
                        mem_data_in_d = req_wdata;
                        state_d       = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (wait_q == LAST_WAIT) begin
                    wait_d = 4'd0;
                    if (!write_q) begin
                        resp_rdata_d = mem_data_out;
                        resp_last_d  = (word_q == len_q);
                        mem_enable_d = 1'b0;
                        rw_enable_d  = 1'b1;
                        state_d      = RESP;
                    end else if (word_q != len_q) begin
                        word_d        = word_inc;
                        mem_address_d = next_addr;
                    end else begin
                        mem_enable_d = 1'b0;
                        rw_enable_d  = 1'b1;
                        resp_rdata_d = 32'd0;
                        resp_last_d  = 1'b1;
                        state_d      = RESP;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (resp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        word_d        = word_inc;
                        wait_d        = 4'd0;
                        mem_enable_d  = 1'b1;
                        rw_enable_d   = 1'b1;
                        mem_address_d = next_addr;
                        state_d       = ACCESS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            write_q       <= 1'b0;
            len_q         <= 4'd0;
            word_q        <= 4'd0;
            wait_q        <= 4'd0;
            resp_rdata_q  <= 32'd0;
            resp_err_q    <= 1'b0;
            resp_last_q   <= 1'b0;
            mem_enable_q  <= 1'b0;
            rw_enable_q   <= 1'b1;
            mem_address_q <= 32'd0;
            mem_data_in_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            write_q       <= write_d;
            len_q         <= len_d;
            word_q        <= word_d;
            wait_q        <= wait_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            resp_last_q   <= resp_last_d;
            mem_enable_q  <= mem_enable_d;
            rw_enable_q   <= rw_enable_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign resp_last   = resp_last_q;
    assign mem_enable  = mem_enable_q;
    assign rw_enable   = rw_enable_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data memory interface: accepts load, store and block requests from the execute stage over a valid/ready handshake.
- Sequences the memory strobes (mem_enable, rw_enable, address, data) with a programmable hold time.
- Returns read data, or a store/error completion, over a valid/ready response channel.
- Supports single-word accesses and bursts of up to 16 consecutive words: read burst or fill-write burst.

Parameters:
- DEPTH, 1024, number of 32-bit words in the attached memory; legal word addresses are 0..DEPTH-1.
- MEM_LATENCY, 1, cycles mem_enable/address/data are held per word (1..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; equals (state==IDLE)
- req_write  input  1  1 = store/fill, 0 = load
- req_addr  input  32  first word address
- req_wdata  input  32  store data; same value is written to every word of a write burst
- req_len  input  4  burst length minus one (0 = single word, 15 = 16 words)
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  read word; 0 for write completions and errors
- resp_err  output  1  request rejected (address range)
- resp_last  output  1  final response of the request
- mem_enable  output  1  memory access strobe
- rw_enable  output  1  memory direction: 0 = write, 1 = read
- mem_address  output  32  word address to memory
- mem_data_in  output  32  write data to memory
- mem_data_out  input  32  combinational read data from memory

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE; resp_valid, resp_err, resp_last, mem_enable = 0; resp_rdata, mem_address, mem_data_in = 0; rw_enable = 1 (read, so no write can occur); word and wait counters = 0.
- Reset mid-burst aborts immediately with no further memory strobes. Words already written stay written.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch addr, wdata, write, len.
  - Range check uses 33-bit arithmetic so there is no wrap: end = addr + len.
  - If end > DEPTH-1, go to RESP with resp_err=1, resp_last=1, resp_rdata=0. No memory strobe is issued.
  - Otherwise go to ACCESS with word counter 0 and wait counter 0.
- ACCESS:
  - mem_enable = 1; rw_enable = ~write; mem_address = addr + word; mem_data_in = wdata.
  - All four are registered and stable for MEM_LATENCY cycles per word.
  - The wait counter counts 0..MEM_LATENCY-1. At the last wait cycle:
    - Read: register mem_data_out into resp_rdata, set resp_last = (word==len), deassert mem_enable, go to RESP.
    - Write, not last word: word+1, wait counter 0, stay in ACCESS. mem_enable stays high and the address advances.
    - Write, last word: deassert mem_enable, set resp_rdata=0, resp_last=1, go to RESP.
- RESP:
  - resp_valid = 1. resp_rdata, resp_err and resp_last are held stable until resp_ready.
  - On resp_ready:
    - If resp_last, go to IDLE; resp_valid drops next cycle.
    - Else (read burst), word+1, go to ACCESS.
- mem_enable is 0 in IDLE and RESP, so memory is never strobed while a response is stalled.
- Read burst of N words yields N responses; only the Nth has resp_last=1. A write burst yields exactly one response.
- Minimum latency, MEM_LATENCY=1: request accepted cycle t, ACCESS t+1, resp_valid t+2. With resp_ready held high, a read burst costs 2 cycles per word.
- req_ready is 0 from acceptance until the cycle after the final response handshake. No request is queued.
- req_* changes after acceptance have no effect (latched copies are used).

Test Plan:
- Single load: model preloaded mem[k]=k; req addr=3, write=0, len=0, resp_ready=1 → one access at mem_address=3, rw_enable=1; resp_rdata=3, resp_last=1, resp_err=0 two cycles after acceptance; req_ready back to 1 next cycle.
- Store then load: store addr=10 data=0xDEADBEEF → mem_enable with rw_enable=0 for exactly MEM_LATENCY cycles, one completion with resp_rdata=0; a following load of addr 10 returns 0xDEADBEEF.
- Read burst with backpressure: addr=0, len=4, resp_ready low 3 cycles per response → five responses 0,1,2,3,4, last flagged only on 4; mem_enable=0 throughout every stall; data held stable while stalled.
- Fill burst with MEM_LATENCY=3: addr=100, len=15, data=0x55 → addresses 100..115, each held 3 cycles, 48 consecutive cycles of mem_enable=1; one response; reading 100..115 back returns 0x55.
- Range errors: addr=1023 len=0 accepted; addr=1020 len=4 → resp_err=1, no mem_enable pulse; addr=0xFFFFFFFF len=15 → resp_err=1, no wrap.
- Async reset asserted mid fill-burst at word 2 → mem_enable, resp_valid drop immediately, rw_enable=1; after release req_ready=1 and a new load completes normally.
